// File: rtl/tia_biphase_clock_pkg.sv
// tia_biphase_pkg: state type and cycle length shared by the biphase clock generator
package tia_biphase_pkg;

    localparam int unsigned CYCLE_LEN = 4;

    typedef enum logic [4:0] {
        RESET = 5'b00001,
        PHI2  = 5'b00010,
        Z1    = 5'b00100,
        PHI1  = 5'b01000,
        Z2    = 5'b10000
    } state_e;

endpackage

// File: rtl/tia_biphase_clock_if.sv
// tia_biphase_clock_if: resync request in, phi1/phi2/rl out
interface tia_biphase_clock_if;

    logic r;
    logic phi1;
    logic phi2;
    logic rl;

    modport master (output r, input phi1, input phi2, input rl);
    modport slave  (input r, output phi1, output phi2, output rl);

endinterface

// File: rtl/tia_biphase_clock.sv
// tia_biphase_clock: divide-by-four non-overlapping phi1/phi2 generator with latched reset; TIA_BIPHASE_CLOCK_ASSERT_EN adds sim-only invariant checks
import tia_biphase_pkg::*;

module tia_biphase_clock (
    input  logic                  clk,
    input  logic                  rst_n,
    tia_biphase_clock_if.slave    bus
);

    state_e state_q, state_d;
    logic   phi1_q, phi2_q, rl_q;

    // next state: resync wins from anywhere, otherwise walk the ring; unknown encodings fall back to RESET
    always_comb begin
        state_d = RESET;
        case (state_q)
            RESET:   state_d = PHI2;
            PHI2:    state_d = Z1;
            Z1:      state_d = PHI1;
            PHI1:    state_d = Z2;
            Z2:      state_d = PHI2;
            default: state_d = RESET;
        endcase
        if (bus.r) state_d = RESET;
    end

    // state register with outputs registered from the next state so they track state_q with no input path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET;
            phi1_q  <= 1'b0;
            phi2_q  <= 1'b0;
            rl_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            phi1_q  <= state_d == PHI1;
            phi2_q  <= state_d == PHI2;
            rl_q    <= state_d == RESET;
        end
    end

    assign bus.phi1 = phi1_q;
    assign bus.phi2 = phi2_q;
    assign bus.rl   = rl_q;

`ifdef TIA_BIPHASE_CLOCK_ASSERT_EN
    // invariants sampled mid-period while outputs are stable
    always @(negedge clk) begin
        if (rst_n) begin
            assert (!(phi1_q && phi2_q)) else $error("phi1 and phi2 both high");
            assert (!rl_q || (!phi1_q && !phi2_q)) else $error("phase active during rl");
            assert (state_q inside {RESET, PHI2, Z1, PHI1, Z2}) else $error("illegal state %b", state_q);
        end
    end
`endif

endmodule

// File: tb/tb_tia_biphase_clock.sv
// tb_tia_biphase_clock: random and directed stimulus against a phase-count reference model
import tia_biphase_pkg::*;

module tb_tia_biphase_clock;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ph = -1;
    int   cnt1, cnt2, both;
    logic seen_phi1;
    logic found;

    tia_biphase_clock_if bus ();

    tia_biphase_clock dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // reference: -1 means held in reset, otherwise edges since leaving reset modulo the cycle length
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || bus.r) ph <= -1;
        else ph <= (ph + 1) % CYCLE_LEN;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".rl"},   32'(bus.rl),   32'(ph == -1));
        check({tag, ".phi2"}, 32'(bus.phi2), 32'(ph == 0));
        check({tag, ".phi1"}, 32'(bus.phi1), 32'(ph == 2));
    endtask

    task automatic step(input logic rv, input string tag);
        bus.r = rv;
        @(negedge clk);
        check_outs(tag);
    endtask

    task automatic seek(input int target, input string tag);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (ph == target) found = 1'b1;
            else step(1'b0, tag);
        end
        check({tag, ".reached"}, 32'(found), 32'd1);
    endtask

    initial begin
        bus.r = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold.rl", 32'(bus.rl), 32'd1);
            check("hold.phases", 32'({bus.phi1, bus.phi2}), 32'd0);
        end
        rst_n = 1'b1;
        step(1'b1, "start_r");
        step(1'b1, "start_r");
        step(1'b0, "start");
        check("start.phi2", 32'(bus.phi2), 32'd1);
        check("start.rl", 32'(bus.rl), 32'd0);
        step(1'b0, "start.z1");
        step(1'b0, "start.phi1");
        check("start.phi1_up", 32'(bus.phi1), 32'd1);
        step(1'b0, "start.z2");
        step(1'b0, "start.phi2b");
        check("start.phi2_again", 32'(bus.phi2), 32'd1);
        cnt1 = 0; cnt2 = 0; both = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b0, "free");
            cnt1 += int'(bus.phi1);
            cnt2 += int'(bus.phi2);
            both += int'(bus.phi1 & bus.phi2);
        end
        check("free.phi1_count", 32'(cnt1), 32'(1000 / CYCLE_LEN));
        check("free.phi2_count", 32'(cnt2), 32'(1000 / CYCLE_LEN));
        check("free.overlap", 32'(both), 32'd0);
        for (int i = 0; i < 300; i++) step($urandom_range(0, 7) == 0, "rand");
        seek(2, "resync.seek");
        check("resync.in_phi1", 32'(bus.phi1), 32'd1);
        step(1'b1, "resync");
        check("resync.rl", 32'(bus.rl), 32'd1);
        check("resync.phi1", 32'(bus.phi1), 32'd0);
        step(1'b0, "resync.restart");
        check("resync.phi2", 32'(bus.phi2), 32'd1);
        seek(0, "async.seek");
        check("async.in_phi2", 32'(bus.phi2), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async.phi2", 32'(bus.phi2), 32'd0);
        check("async.rl", 32'(bus.rl), 32'd1);
        @(negedge clk);
        check_outs("async.held");
        rst_n = 1'b1;
        step(1'b0, "async.release");
        check("async.release_phi2", 32'(bus.phi2), 32'd1);
        seen_phi1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(i[0] == 1'b0, "b2b");
            check("b2b.rl", 32'(bus.rl), 32'(i[0] == 1'b0));
            seen_phi1 |= bus.phi1;
        end
        check("b2b.no_phi1", 32'(seen_phi1), 32'd0);
        step(1'b0, "tail");
        step(1'b0, "tail");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
